// File: rtl/alu_pkg.sv
// Opcodes, FSM state encoding and opcode-class helpers shared by alu_mc and its MDU.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_SLL   = 4'd4;
  localparam logic [3:0] OP_SLTU  = 4'd5;
  localparam logic [3:0] OP_SLT   = 4'd6;
  localparam logic [3:0] OP_XOR   = 4'd7;
  localparam logic [3:0] OP_LUI   = 4'd8;
  localparam logic [3:0] OP_NOR   = 4'd9;
  localparam logic [3:0] OP_SRL   = 4'd10;
  localparam logic [3:0] OP_SRA   = 4'd11;
  localparam logic [3:0] OP_MULTU = 4'd12;
  localparam logic [3:0] OP_MULT  = 4'd13;
  localparam logic [3:0] OP_DIVU  = 4'd14;
  localparam logic [3:0] OP_DIV   = 4'd15;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

  // Multiply/divide occupy the top quarter of the opcode space.
  function automatic logic is_iter(input logic [3:0] op);
    return op[3:2] == 2'b11;
  endfunction

  function automatic logic op_is_div(input logic [3:0] op);
    return op[3:1] == 3'b111;
  endfunction

  // Odd iterative opcodes are the signed variants.
  function automatic logic op_is_signed(input logic [3:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Operation request / result handshake bundle for alu_mc.
interface alu_mc_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] rega;
  logic [WIDTH-1:0] regb;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;
  logic             zero;
  logic             ovf;
  logic             dbz;

  modport master (
    output in_valid, opcode, rega, regb, out_ready,
    input  in_ready, out_valid, res_lo, res_hi, zero, ovf, dbz
  );

  modport slave (
    input  in_valid, opcode, rega, regb, out_ready,
    output in_ready, out_valid, res_lo, res_hi, zero, ovf, dbz
  );
endinterface

// File: rtl/alu_mc_mdu_iter.sv
// Unsigned iterative multiply/divide: shift-add multiplier and restoring divider
// sharing one 2*WIDTH accumulator. The first iteration happens on the start edge,
// so WIDTH iterations end WIDTH-1 edges later; done/hi/lo are the combinational
// outcome of the iteration being performed on the current edge.
module mdu_iter #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_q, acc_d, acc_src;
  logic [WIDTH-1:0]   m_q, m_src;
  logic               div_q, div_src;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;

  // One iteration. Mul: acc = {partial, multiplier}, add-then-shift-right.
  // Div: acc = {remainder, dividend/quotient}, shift-left-then-trial-subtract.
  function automatic logic [2*WIDTH-1:0] step(input logic [2*WIDTH-1:0] acc,
                                              input logic [WIDTH-1:0] m,
                                              input logic div);
    logic [WIDTH:0]       t;
    logic [2*WIDTH-1:0]   r;
    if (div) begin
      t = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      if (t >= {1'b0, m}) begin
        t = t - {1'b0, m};
        r = {t[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        r = {t[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      t = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
      r = {t, acc[WIDTH-1:1]};
    end
    return r;
  endfunction

  // On start the iteration runs on the freshly presented operands.
  always_comb begin
    acc_src = acc_q;
    m_src   = m_q;
    div_src = div_q;
    if (start) begin
      acc_src = is_div ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
      m_src   = is_div ? b : a;
      div_src = is_div;
    end
    acc_d = step(acc_src, m_src, div_src);
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign hi   = acc_d[2*WIDTH-1:WIDTH];
  assign lo   = acc_d[WIDTH-1:0];

  // Accumulator, operand and iteration counter; cnt_q = iterations already done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      m_q    <= '0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      acc_q  <= acc_d;
      m_q    <= m_src;
      div_q  <= div_src;
      cnt_q  <= CW'(1);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + CW'(1);
      if (done) busy_q <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle simple ops, iterative signed/unsigned mul/div,
// registered results held until the consumer takes them.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic   clk,
  input logic   rst_n,
  alu_mc_if.slave bus
);
  state_e           state_q;
  logic             out_valid_q, zero_q, ovf_q, dbz_q;
  logic [WIDTH-1:0] res_lo_q, res_hi_q;
  logic             div_q, neg_lo_q, neg_hi_q;

  logic [3:0]       op;
  logic [WIDTH-1:0] a, b, sum, diff, slo_d, mag_a, mag_b;
  logic [SHW-1:0]   sh;
  logic             sovf_d, accept, dz, start, a_neg, b_neg;
  logic             mdu_busy, mdu_done;
  logic [WIDTH-1:0] mdu_hi, mdu_lo, fix_hi_d, fix_lo_d;
  logic [2*WIDTH-1:0] prod_d;

  assign op   = bus.opcode;
  assign a    = bus.rega;
  assign b    = bus.regb;
  assign sh   = a[SHW-1:0];
  assign sum  = a + b;
  assign diff = a - b;

  assign bus.in_ready = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;
  assign dz     = op_is_div(op) && (b == '0);
  assign start  = accept && is_iter(op) && !dz;

  // Signed mul/div run on magnitudes; the result signs are restored on completion.
  assign a_neg = op_is_signed(op) && a[WIDTH-1];
  assign b_neg = op_is_signed(op) && b[WIDTH-1];
  assign mag_a = a_neg ? -a : a;
  assign mag_b = b_neg ? -b : b;

  mdu_iter #(.WIDTH(WIDTH)) u_mdu (
    .clk(clk), .rst_n(rst_n), .start(start), .is_div(op_is_div(op)),
    .a(mag_a), .b(mag_b), .busy(mdu_busy), .done(mdu_done), .hi(mdu_hi), .lo(mdu_lo)
  );

  // Single-cycle datapath and signed-overflow detect for ADD/SUB.
  always_comb begin
    slo_d  = '0;
    sovf_d = 1'b0;
    case (op)
      OP_ADD:  begin slo_d = sum;  sovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]); end
      OP_SUB:  begin slo_d = diff; sovf_d = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]); end
      OP_AND:  slo_d = a & b;
      OP_OR:   slo_d = a | b;
      OP_XOR:  slo_d = a ^ b;
      OP_NOR:  slo_d = ~(a | b);
      OP_SLL:  slo_d = b << sh;
      OP_SRL:  slo_d = b >> sh;
      OP_SRA:  slo_d = WIDTH'($signed(b) >>> sh);
      OP_SLTU: slo_d = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLT:  slo_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_LUI:  slo_d = b << (WIDTH / 2);
      default: slo_d = '0;
    endcase
  end

  // Sign fix-up: product negates as one 2*WIDTH value, quotient/remainder separately.
  always_comb begin
    prod_d   = {mdu_hi, mdu_lo};
    fix_lo_d = mdu_lo;
    fix_hi_d = mdu_hi;
    if (div_q) begin
      if (neg_lo_q) fix_lo_d = -mdu_lo;
      if (neg_hi_q) fix_hi_d = -mdu_hi;
    end else if (neg_lo_q) begin
      prod_d   = -prod_d;
      fix_lo_d = prod_d[WIDTH-1:0];
      fix_hi_d = prod_d[2*WIDTH-1:WIDTH];
    end
  end

  // Control FSM with registered result/flag outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      res_lo_q    <= '0;
      res_hi_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
      div_q       <= 1'b0;
      neg_lo_q    <= 1'b0;
      neg_hi_q    <= 1'b0;
    end else begin
      case (state_q)
        BUSY: if (mdu_done) begin
          state_q     <= DONE;
          out_valid_q <= 1'b1;
          res_lo_q    <= fix_lo_d;
          res_hi_q    <= fix_hi_d;
          zero_q      <= (fix_lo_d == '0);
          ovf_q       <= 1'b0;
          dbz_q       <= 1'b0;
        end
        IDLE, DONE: if (start) begin
          state_q     <= BUSY;
          out_valid_q <= 1'b0;
          div_q       <= op_is_div(op);
          neg_lo_q    <= a_neg ^ b_neg;
          neg_hi_q    <= a_neg;
        end else if (accept) begin
          state_q     <= DONE;
          out_valid_q <= 1'b1;
          res_lo_q    <= dz ? '1 : slo_d;
          res_hi_q    <= dz ? a  : '0;
          zero_q      <= dz ? 1'b0 : (slo_d == '0);
          ovf_q       <= dz ? 1'b0 : sovf_d;
          dbz_q       <= dz;
        end else if (state_q == DONE && bus.out_ready) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.res_lo    = res_lo_q;
  assign bus.res_hi    = res_hi_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;
  assign bus.dbz       = dbz_q;
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed cases plus randomized ops against an arithmetic reference.
module tb_alu_mc;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(W)) bus();
  alu_mc #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         z;
    logic         o;
    logic         d;
  } res_t;

  // Reference: results straight from the opcode table using wide integer arithmetic.
  function automatic res_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t r;
    longint sa, sb, s, q, rm;
    logic [63:0] t, pu;
    logic signed [W-1:0] bs;
    int sh;
    sa = $signed(a);
    sb = $signed(b);
    sh = int'(a % W);
    bs = b;
    r = '0;
    case (op)
      4'd0:  begin r.lo = a + b; s = sa + sb; r.o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd1:  begin r.lo = a - b; s = sa - sb; r.o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd2:  r.lo = a & b;
      4'd3:  r.lo = a | b;
      4'd7:  r.lo = a ^ b;
      4'd9:  r.lo = ~(a | b);
      4'd4:  r.lo = b << sh;
      4'd10: r.lo = b >> sh;
      4'd11: r.lo = bs >>> sh;
      4'd5:  r.lo = (a < b) ? 1 : 0;
      4'd6:  r.lo = (sa < sb) ? 1 : 0;
      4'd8:  r.lo = b << (W / 2);
      4'd12: begin pu = 64'(a) * 64'(b); r.lo = pu[31:0]; r.hi = pu[63:32]; end
      4'd13: begin t = sa * sb; r.lo = t[31:0]; r.hi = t[63:32]; end
      4'd14: if (b == 0) begin r.lo = '1; r.hi = a; r.d = 1'b1; end
             else begin r.lo = a / b; r.hi = a % b; end
      default: if (b == 0) begin r.lo = '1; r.hi = a; r.d = 1'b1; end
             else begin q = sa / sb; rm = sa % sb; t = q; r.lo = t[31:0]; t = rm; r.hi = t[31:0]; end
    endcase
    r.z = (r.lo == 0);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input res_t e);
    chk({tag, " lo"},  bus.res_lo, e.lo);
    chk({tag, " hi"},  bus.res_hi, e.hi);
    chk({tag, " zero"}, W'(bus.zero), W'(e.z));
    chk({tag, " ovf"},  W'(bus.ovf),  W'(e.o));
    chk({tag, " dbz"},  W'(bus.dbz),  W'(e.d));
  endtask

  // Present op from a negedge and return just after the accepting posedge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int k;
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.rega     = a;
    bus.regb     = b;
    k = 0;
    while (!bus.in_ready && k < 200) begin @(negedge clk); k++; end
    chk("accept_wait", W'(k < 200), W'(1));
    @(posedge clk);
  endtask

  // Full transaction with out_ready high: latency, in_ready during BUSY, results.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat, exp_lat;
    logic rdy_seen;
    string tag;
    tag = $sformatf("op%0d a=%0h b=%0h", op, a, b);
    exp_lat = (op >= 12 && !(op >= 14 && b == 0)) ? W : 1;
    @(negedge clk);
    issue(op, a, b);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.rega = $urandom;
    bus.regb = $urandom;
    lat = 1;
    rdy_seen = 1'b0;
    while (!bus.out_valid && lat < 200) begin
      if (bus.in_ready) rdy_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, W'(lat), W'(exp_lat));
    if (exp_lat > 1) chk({tag, " in_ready_busy"}, W'(rdy_seen), W'(0));
    chk_res(tag, model(op, a, b));
  endtask

  initial begin
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic         seen;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.opcode    = '0;
    bus.rega      = '0;
    bus.regb      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst in_ready",  W'(bus.in_ready),  W'(1));
    chk("rst out_valid", W'(bus.out_valid), W'(0));
    chk_res("rst", '0);
    rst_n = 1'b1;

    run_op(4'd0,  32'h7FFF_FFFF, 32'h1);
    run_op(4'd13, 32'hFFFF_FFFE, 32'h3);
    run_op(4'd15, 32'hFFFF_FFF9, 32'h2);
    run_op(4'd14, 32'd100, 32'h0);
    run_op(4'd15, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(4'd8,  32'h0, 32'h0000_1234);

    // SLT then SLTU on consecutive cycles.
    @(negedge clk);
    issue(4'd6, 32'hFFFF_FFFF, 32'h1);
    @(negedge clk);
    chk("b2b slt valid", W'(bus.out_valid), W'(1));
    chk("b2b slt lo",    bus.res_lo,        W'(1));
    chk("b2b in_ready",  W'(bus.in_ready),  W'(1));
    bus.opcode = 4'd5;
    @(posedge clk);
    @(negedge clk);
    chk("b2b sltu valid", W'(bus.out_valid), W'(1));
    chk("b2b sltu lo",    bus.res_lo,        W'(0));
    chk("b2b in_ready2",  W'(bus.in_ready),  W'(1));
    bus.in_valid = 1'b0;

    // Consumer stall: result held, next op waits.
    @(negedge clk);
    bus.out_ready = 1'b0;
    issue(4'd11, 32'd4, 32'h8000_0000);
    @(negedge clk);
    bus.opcode = 4'd0; bus.rega = 32'd1; bus.regb = 32'd2;
    for (int i = 0; i < 5; i++) begin
      chk("stall valid",    W'(bus.out_valid), W'(1));
      chk("stall lo",       bus.res_lo,        32'hF800_0000);
      chk("stall in_ready", W'(bus.in_ready),  W'(0));
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("after stall valid", W'(bus.out_valid), W'(1));
    chk("after stall lo",    bus.res_lo,        W'(3));

    // Reset in the middle of a divide.
    @(negedge clk);
    issue(4'd14, 32'd1000, 32'd7);
    bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst in_ready",  W'(bus.in_ready),  W'(1));
    chk("midrst out_valid", W'(bus.out_valid), W'(0));
    chk_res("midrst", '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (bus.out_valid) seen = 1'b1; end
    chk("midrst no result", W'(seen), W'(0));

    // Randomized ops, biased toward divide-by-zero and overflow corners.
    for (int n = 0; n < 60; n++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = '1; end
        2: b = W'($urandom_range(1, 9));
        3: a = W'($urandom_range(0, 40));
        default: ;
      endcase
      run_op(op, a, b);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
